// File: rtl/btn_pkg.sv
// Shared definitions for the push-button front end: button bit positions,
// the auto-repeat state encoding and a small constant helper for sizing.
package btn_pkg;

    // Bit positions of the five board buttons inside every NBTN-wide bus
    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_U = 2;
    localparam int BTN_D = 3;
    localparam int BTN_C = 4;

    // Auto-repeat sequencer states
    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_DELAY  = 2'd1,
        R_REPEAT = 2'd2
    } rpt_state_t;

    // Larger of two integers, used to size the shared repeat timer
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One push-button: two-flop synchroniser, stability-count debouncer,
// registered press/release pulses and a press/auto-repeat pulse sequencer.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DB_CYCLES  = 400_000,
    parameter int RPT_DELAY  = 20_000_000,
    parameter int RPT_PERIOD = 4_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic dn,
    output logic up,
    output logic rpt
);

    localparam int DB_W  = cnt_width(DB_CYCLES);
    localparam int RPT_W = cnt_width(max_int(RPT_DELAY, RPT_PERIOD));

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DB_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(RPT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(RPT_PERIOD - 1);

    logic             sync_a;
    logic             sync_b;
    logic             stable;
    logic [DB_W-1:0]  db_cnt;
    logic [RPT_W-1:0] timer;
    rpt_state_t       state;

    logic differs;
    logic accept;
    logic press;
    logic release_ev;

    // A level change is accepted on the cycle its count reaches the last value
    assign differs    = (sync_b != stable);
    assign accept     = differs && (db_cnt == DB_LAST);
    assign press      = accept && sync_b;
    assign release_ev = accept && !sync_b;
    assign level      = stable;

    // Bring the asynchronous raw level into the clock domain
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Accept a new level only after it has differed for DB_CYCLES cycles in a row
    always_ff @(posedge clk) begin
        if (!rst) begin
            stable <= 1'b0;
            db_cnt <= '0;
            dn     <= 1'b0;
            up     <= 1'b0;
        end else begin
            dn <= press;
            up <= release_ev;
            if (!differs) begin
                db_cnt <= '0;
            end else if (accept) begin
                stable <= sync_b;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // Pulse on press, again after the initial delay, then once per period while held
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= R_IDLE;
            timer <= '0;
            rpt   <= 1'b0;
        end else begin
            rpt <= 1'b0;
            if (release_ev) begin
                state <= R_IDLE;
                timer <= '0;
            end else begin
                case (state)
                    R_IDLE: begin
                        timer <= '0;
                        if (press) begin
                            rpt   <= 1'b1;
                            state <= R_DELAY;
                        end
                    end
                    R_DELAY: begin
                        if (timer == DELAY_LAST) begin
                            rpt   <= 1'b1;
                            timer <= '0;
                            state <= R_REPEAT;
                        end else begin
                            timer <= timer + RPT_W'(1);
                        end
                    end
                    R_REPEAT: begin
                        if (timer == PERIOD_LAST) begin
                            rpt   <= 1'b1;
                            timer <= '0;
                        end else begin
                            timer <= timer + RPT_W'(1);
                        end
                    end
                    default: begin
                        state <= R_IDLE;
                        timer <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Board push-button front end: one independent conditioning channel per
// button, outputs gathered into NBTN-wide buses for the control core.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int NBTN       = 5,
    parameter int DB_CYCLES  = 400_000,
    parameter int RPT_DELAY  = 20_000_000,
    parameter int RPT_PERIOD = 4_000_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] btn_raw,
    output logic [NBTN-1:0] btn,
    output logic [NBTN-1:0] btn_dn,
    output logic [NBTN-1:0] btn_up,
    output logic [NBTN-1:0] btn_rpt
);

    // Buttons never interact, so each bit gets its own complete channel
    for (genvar i = 0; i < NBTN; i++) begin : g_chan
        btn_channel #(
            .DB_CYCLES (DB_CYCLES),
            .RPT_DELAY (RPT_DELAY),
            .RPT_PERIOD(RPT_PERIOD)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .raw  (btn_raw[i]),
            .level(btn[i]),
            .dn   (btn_dn[i]),
            .up   (btn_up[i]),
            .rpt  (btn_rpt[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timing.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_button_conditioner;

    localparam int NBTN = 5;

    logic            clk;
    logic            rst;
    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] btn;
    logic [NBTN-1:0] btn_dn;
    logic [NBTN-1:0] btn_up;
    logic [NBTN-1:0] btn_rpt;

    int errors;
    int checks;
    int dn_cnt  [NBTN];
    int up_cnt  [NBTN];
    int rpt_cnt [NBTN];

    button_conditioner #(
        .NBTN      (NBTN),
        .DB_CYCLES (4),
        .RPT_DELAY (10),
        .RPT_PERIOD(3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_raw),
        .btn    (btn),
        .btn_dn (btn_dn),
        .btn_up (btn_up),
        .btn_rpt(btn_rpt)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n falling edges, tallying every pulse seen per button
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int b = 0; b < NBTN; b++) begin
                dn_cnt[b]  += int'(btn_dn[b]);
                up_cnt[b]  += int'(btn_up[b]);
                rpt_cnt[b] += int'(btn_rpt[b]);
            end
        end
    endtask

    task automatic clear_counts();
        for (int b = 0; b < NBTN; b++) begin
            dn_cnt[b]  = 0;
            up_cnt[b]  = 0;
            rpt_cnt[b] = 0;
        end
    endtask

    task automatic applyStimulus(input logic [NBTN-1:0] value);
        btn_raw = value;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst     = 1'b0;
        btn_raw = '0;
        clear_counts();

        // Reset state
        tick(3);
        checkOutput("reset_btn", 32'(btn), 32'h0);
        checkOutput("reset_dn", 32'(btn_dn), 32'h0);
        checkOutput("reset_up", 32'(btn_up), 32'h0);
        checkOutput("reset_rpt", 32'(btn_rpt), 32'h0);
        rst = 1'b1;
        tick(2);

        // Clean press of L held 30 cycles, repeats at press +10, +13, +16 ...
        $display("[TB] clean press and auto-repeat on L");
        clear_counts();
        applyStimulus(5'b00001);
        tick(5);
        checkOutput("l_before_accept", 32'(btn), 32'h0);
        tick(1);
        checkOutput("l_btn_rise", 32'(btn), 32'h01);
        checkOutput("l_dn_pulse", 32'(btn_dn), 32'h01);
        checkOutput("l_rpt_press", 32'(btn_rpt), 32'h01);
        tick(1);
        checkOutput("l_dn_one_cycle", 32'(btn_dn), 32'h0);
        checkOutput("l_rpt_one_cycle", 32'(btn_rpt), 32'h0);
        tick(8);
        checkOutput("l_rpt_p9_quiet", 32'(btn_rpt), 32'h0);
        tick(1);
        checkOutput("l_rpt_p10", 32'(btn_rpt), 32'h01);
        tick(1);
        checkOutput("l_rpt_p11_quiet", 32'(btn_rpt), 32'h0);
        tick(2);
        checkOutput("l_rpt_p13", 32'(btn_rpt), 32'h01);
        tick(3);
        checkOutput("l_rpt_p16", 32'(btn_rpt), 32'h01);
        tick(8);
        applyStimulus(5'b00000);
        tick(5);
        checkOutput("l_btn_before_release", 32'(btn), 32'h01);
        tick(1);
        checkOutput("l_btn_fall", 32'(btn), 32'h0);
        checkOutput("l_up_pulse", 32'(btn_up), 32'h01);
        tick(1);
        checkOutput("l_up_one_cycle", 32'(btn_up), 32'h0);
        tick(10);
        checkOutput("l_rpt_total", 32'(rpt_cnt[0]), 32'd8);
        checkOutput("l_dn_total", 32'(dn_cnt[0]), 32'd1);
        checkOutput("l_up_total", 32'(up_cnt[0]), 32'd1);

        // Glitch on U: 3 cycles rejected, 4 cycles accepted
        $display("[TB] glitch rejection on U");
        clear_counts();
        applyStimulus(5'b00100);
        tick(3);
        applyStimulus(5'b00000);
        tick(10);
        checkOutput("u_glitch_btn", 32'(btn), 32'h0);
        checkOutput("u_glitch_dn", 32'(dn_cnt[2]), 32'd0);
        checkOutput("u_glitch_rpt", 32'(rpt_cnt[2]), 32'd0);
        applyStimulus(5'b00100);
        tick(4);
        applyStimulus(5'b00000);
        tick(2);
        checkOutput("u_four_btn", 32'(btn), 32'h04);
        checkOutput("u_four_dn", 32'(btn_dn), 32'h04);
        tick(5);
        checkOutput("u_four_release", 32'(btn), 32'h0);
        checkOutput("u_four_up_total", 32'(up_cnt[2]), 32'd1);
        checkOutput("u_four_rpt_total", 32'(rpt_cnt[2]), 32'd1);
        tick(5);

        // D released after 8 held cycles: release pulse, only the press repeat
        $display("[TB] short hold on D");
        clear_counts();
        applyStimulus(5'b01000);
        tick(8);
        applyStimulus(5'b00000);
        tick(5);
        checkOutput("d_btn_held", 32'(btn), 32'h08);
        checkOutput("d_up_early", 32'(btn_up), 32'h0);
        tick(1);
        checkOutput("d_up_pulse", 32'(btn_up), 32'h08);
        checkOutput("d_btn_fall", 32'(btn), 32'h0);
        tick(2);
        checkOutput("d_no_delay_rpt", 32'(btn_rpt), 32'h0);
        tick(14);
        checkOutput("d_rpt_total", 32'(rpt_cnt[3]), 32'd1);

        // R and C pressed one cycle apart, independent repeat trains
        $display("[TB] skewed simultaneous press on R and C");
        clear_counts();
        applyStimulus(5'b00010);
        tick(1);
        applyStimulus(5'b10010);
        tick(5);
        checkOutput("rc_dn_r", 32'(btn_dn), 32'h02);
        tick(1);
        checkOutput("rc_dn_c", 32'(btn_dn), 32'h10);
        checkOutput("rc_rpt_c_press", 32'(btn_rpt), 32'h10);
        checkOutput("rc_btn_both", 32'(btn), 32'h12);
        tick(9);
        checkOutput("rc_rpt_r_first", 32'(btn_rpt), 32'h02);
        tick(1);
        checkOutput("rc_rpt_c_first", 32'(btn_rpt), 32'h10);
        tick(2);
        checkOutput("rc_rpt_r_second", 32'(btn_rpt), 32'h02);
        tick(1);
        checkOutput("rc_rpt_c_second", 32'(btn_rpt), 32'h10);
        tick(1);
        applyStimulus(5'b00000);
        tick(6);
        checkOutput("rc_up_both", 32'(btn_up), 32'h12);
        tick(5);
        checkOutput("rc_rpt_total_r", 32'(rpt_cnt[1]), 32'd5);
        checkOutput("rc_rpt_total_c", 32'(rpt_cnt[4]), 32'd5);

        // Reset while L is in the repeat phase, then re-detection after 6 edges
        $display("[TB] reset during auto-repeat");
        clear_counts();
        applyStimulus(5'b00001);
        tick(18);
        rst = 1'b0;
        tick(1);
        checkOutput("rst_mid_btn", 32'(btn), 32'h0);
        checkOutput("rst_mid_dn", 32'(btn_dn), 32'h0);
        checkOutput("rst_mid_up", 32'(btn_up), 32'h0);
        checkOutput("rst_mid_rpt", 32'(btn_rpt), 32'h0);
        tick(2);
        rst = 1'b1;
        tick(5);
        checkOutput("rst_redetect_early", 32'(btn), 32'h0);
        tick(1);
        checkOutput("rst_redetect_btn", 32'(btn), 32'h01);
        checkOutput("rst_redetect_dn", 32'(btn_dn), 32'h01);
        checkOutput("rst_redetect_rpt", 32'(btn_rpt), 32'h01);
        applyStimulus(5'b00000);
        tick(10);
        checkOutput("rst_release_btn", 32'(btn), 32'h0);

        // Bounce 1,0,1,1,1,1 on D then held: accepted once, after the last stable run
        $display("[TB] bounce sequence on D");
        clear_counts();
        begin
            logic [5:0] bounce;
            bounce = 6'b111101;
            for (int i = 0; i < 6; i++) begin
                btn_raw[3] = bounce[i];
                tick(1);
            end
        end
        tick(1);
        checkOutput("bounce_not_yet", 32'(btn), 32'h0);
        tick(1);
        checkOutput("bounce_dn", 32'(btn_dn), 32'h08);
        applyStimulus(5'b00000);
        tick(12);
        checkOutput("bounce_dn_total", 32'(dn_cnt[3]), 32'd1);
        checkOutput("bounce_up_total", 32'(up_cnt[3]), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
